phy_init_seq: RTL

Ethernet PHY bring-up sequencer sitting between the board reset generator and the external PHY pins, in the 125 MHz domain. It holds the PHY in hardware reset, waits for PHY power-up, then issues one IEEE 802.3 clause-22 MDIO register write and flags completion. The MAC and DMA logic use `init_done` to gate traffic until the PHY is configured.

---
 rtl/phy_init_seq_if.sv | 21 ++
 rtl/phy_init_seq.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/phy_init_seq_if.sv
// PHY-side pin bundle of the bring-up sequencer plus its start/status handshake.
// start is a single-cycle level sampled on the rising clk edge; it is honoured only while init_done=1.
interface phy_init_seq_if;
  logic start;
  logic phy_reset_n;
  logic mdc;
  logic mdio_o;
  logic mdio_oe;
  logic busy;
  logic init_done;

  modport master (
    input  start,
    output phy_reset_n, mdc, mdio_o, mdio_oe, busy, init_done
  );

  modport slave (
    output start,
    input  phy_reset_n, mdc, mdio_o, mdio_oe, busy, init_done
  );
endinterface

// File: rtl/phy_init_seq.sv
// Ethernet PHY bring-up: hold PHY reset, wait for power-up, issue one clause-22
// MDIO write, then flag init_done. All outputs registered.
module phy_init_seq #(
  parameter logic [31:0] RESET_CYCLES = 32'd1250000,
  parameter logic [31:0] WAIT_CYCLES  = 32'd6250000,
  parameter logic [31:0] MDC_DIV      = 32'd25,
  parameter logic [4:0]  PHY_ADDR     = 5'd0,
  parameter logic [4:0]  REG_ADDR     = 5'd0,
  parameter logic [15:0] REG_DATA     = 16'h1140
) (
  input  logic              clk,
  input  logic              resetn,
  phy_init_seq_if.master    bus,
  output logic [1:0]        o_dbg_state
);

  typedef enum logic [1:0] {
    ST_RST_HOLD  = 2'd0,
    ST_RST_WAIT  = 2'd1,
    ST_MDIO_XFER = 2'd2,
    ST_DONE      = 2'd3
  } state_e;

  localparam logic [63:0] FRAME = {32'hFFFF_FFFF, 2'b01, 2'b01, PHY_ADDR, REG_ADDR, 2'b10, REG_DATA};

  state_e      r_state, w_state;
  logic [31:0] r_cnt, w_cnt;
  logic [31:0] r_div, w_div;
  logic [5:0]  r_bit, w_bit;
  logic [63:0] r_shift, w_shift;
  logic        r_phy_reset_n, w_phy_reset_n;
  logic        r_mdc, w_mdc;
  logic        r_mdio_o, w_mdio_o;
  logic        r_mdio_oe, w_mdio_oe;
  logic        r_busy, w_busy;
  logic        r_init_done, w_init_done;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= ST_RST_HOLD;
      r_cnt         <= '0;
      r_div         <= '0;
      r_bit         <= '0;
      r_shift       <= '0;
      r_phy_reset_n <= 1'b0;
      r_mdc         <= 1'b0;
      r_mdio_o      <= 1'b1;
      r_mdio_oe     <= 1'b0;
      r_busy        <= 1'b1;
      r_init_done   <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_cnt         <= w_cnt;
      r_div         <= w_div;
      r_bit         <= w_bit;
      r_shift       <= w_shift;
      r_phy_reset_n <= w_phy_reset_n;
      r_mdc         <= w_mdc;
      r_mdio_o      <= w_mdio_o;
      r_mdio_oe     <= w_mdio_oe;
      r_busy        <= w_busy;
      r_init_done   <= w_init_done;
    end
  end

  always_comb begin
    w_state       = r_state;
    w_cnt         = r_cnt;
    w_div         = r_div;
    w_bit         = r_bit;
    w_shift       = r_shift;
    w_phy_reset_n = r_phy_reset_n;
    w_mdc         = r_mdc;
    w_mdio_o      = r_mdio_o;
    w_mdio_oe     = r_mdio_oe;
    w_busy        = r_busy;
    w_init_done   = r_init_done;

    case (r_state)
      ST_RST_HOLD: begin
        w_phy_reset_n = 1'b0;
        w_busy        = 1'b1;
        if (r_cnt == RESET_CYCLES - 32'd1) begin
          w_state       = ST_RST_WAIT;
          w_phy_reset_n = 1'b1;
          w_cnt         = '0;
        end else begin
          w_cnt = r_cnt + 32'd1;
        end
      end

      ST_RST_WAIT: begin
        if (r_cnt == WAIT_CYCLES - 32'd1) begin
          w_state   = ST_MDIO_XFER;
          w_cnt     = '0;
          w_div     = '0;
          w_bit     = '0;
          w_shift   = FRAME;
          w_mdio_oe = 1'b1;
          w_mdio_o  = FRAME[63];
          w_mdc     = 1'b0;
        end else begin
          w_cnt = r_cnt + 32'd1;
        end
      end

      ST_MDIO_XFER: begin
        if (r_div == MDC_DIV - 32'd1) begin
          w_div = '0;
          w_mdc = ~r_mdc;
          // Data moves only on the falling MDC edge so it is stable around each rise.
          if (r_mdc) begin
            if (r_bit == 6'd63) begin
              w_state     = ST_DONE;
              w_mdio_oe   = 1'b0;
              w_mdio_o    = 1'b1;
              w_busy      = 1'b0;
              w_init_done = 1'b1;
            end else begin
              w_bit    = r_bit + 6'd1;
              w_shift  = r_shift << 1;
              w_mdio_o = r_shift[62];
            end
          end
        end else begin
          w_div = r_div + 32'd1;
        end
      end

      ST_DONE: begin
        w_busy      = 1'b0;
        w_init_done = 1'b1;
        if (bus.start) begin
          w_state       = ST_RST_HOLD;
          w_phy_reset_n = 1'b0;
          w_init_done   = 1'b0;
          w_busy        = 1'b1;
          w_cnt         = '0;
          w_div         = '0;
          w_bit         = '0;
        end
      end

      default: w_state = ST_RST_HOLD;
    endcase
  end

  assign bus.phy_reset_n = r_phy_reset_n;
  assign bus.mdc         = r_mdc;
  assign bus.mdio_o      = r_mdio_o;
  assign bus.mdio_oe     = r_mdio_oe;
  assign bus.busy        = r_busy;
  assign bus.init_done   = r_init_done;
  assign o_dbg_state     = r_state;

endmodule
